sdram_arbiter: RTL

Two-master Avalon-MM arbiter placed in front of the platform SDRAM controller slave port. Master 0 is the Nios data master path; master 1 is a streaming/DMA client. Each master sees a private, pipelined-read Avalon-MM slave. The block grants the single SDRAM port round-robin, holds commands stable under waitrequest, and routes pipelined read data back to its originator through a tag FIFO.

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/sdram_arb_tag_fifo.sv | 52 +++++
 rtl/sdram_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the two-master SDRAM arbiter.
// Sized for a 32M x 16-bit SDRAM.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF    = 25;
  localparam int DATA_W_DEF    = 16;
  localparam int BE_W_DEF      = 2;
  localparam int TAG_DEPTH_DEF = 8;

  typedef logic mid_t;

  typedef enum logic [1:0] {
    ARB,
    LOCK0,
    LOCK1
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO recording which master issued each outstanding SDRAM read.
// A push into a full FIFO is legal when a pop happens in the same cycle.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  mid_t                     din,
  input  logic                     pop,
  output mid_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  mid_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin two-master Avalon-MM arbiter in front of the SDRAM controller,
// with grant locking under waitrequest and tag-routed pipelined read data.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BE_W      = BE_W_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic [ADDR_W-1:0]            m0_address,
  input  logic                         m0_read,
  input  logic                         m0_write,
  input  logic [DATA_W-1:0]            m0_writedata,
  input  logic [BE_W-1:0]              m0_byteenable,
  output logic                         m0_waitrequest,
  output logic [DATA_W-1:0]            m0_readdata,
  output logic                         m0_readdatavalid,
  input  logic [ADDR_W-1:0]            m1_address,
  input  logic                         m1_read,
  input  logic                         m1_write,
  input  logic [DATA_W-1:0]            m1_writedata,
  input  logic [BE_W-1:0]              m1_byteenable,
  output logic                         m1_waitrequest,
  output logic [DATA_W-1:0]            m1_readdata,
  output logic                         m1_readdatavalid,
  output logic [ADDR_W-1:0]            s_address,
  output logic                         s_read,
  output logic                         s_write,
  output logic [DATA_W-1:0]            s_writedata,
  output logic [BE_W-1:0]              s_byteenable,
  input  logic                         s_waitrequest,
  input  logic [DATA_W-1:0]            s_readdata,
  input  logic                         s_readdatavalid,
  output logic [$clog2(TAG_DEPTH):0]   pend_count,
  output logic                         err_rdv
);

  arb_state_t state, state_n;
  mid_t       ptr, ptr_n;
  mid_t       gnt;
  logic       gnt_vld;
  logic       sel_read, sel_write;
  logic       accept;
  logic       rd_ok, elig0, elig1;
  logic       fifo_full, fifo_empty, pop;
  mid_t       head;

  assign pop   = s_readdatavalid & ~fifo_empty;
  // A pop in the same cycle frees the slot the new read will take.
  assign rd_ok = ~fifo_full | pop;
  assign elig0 = (m0_read | m0_write) & (~m0_read | rd_ok);
  assign elig1 = (m1_read | m1_write) & (~m1_read | rd_ok);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= ARB;
      ptr   <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt     = ptr;
    gnt_vld = 1'b0;
    case (state)
      ARB: begin
        if (elig0 && elig1) begin
          gnt     = ptr;
          gnt_vld = 1'b1;
        end else if (elig0) begin
          gnt     = 1'b0;
          gnt_vld = 1'b1;
        end else if (elig1) begin
          gnt     = 1'b1;
          gnt_vld = 1'b1;
        end
      end
      LOCK0: begin
        gnt     = 1'b0;
        gnt_vld = m0_read | m0_write;
      end
      LOCK1: begin
        gnt     = 1'b1;
        gnt_vld = m1_read | m1_write;
      end
      default: begin
        gnt_vld = 1'b0;
      end
    endcase
    if (reset_reset) gnt_vld = 1'b0;

    sel_read     = gnt ? m1_read  : m0_read;
    sel_write    = gnt ? m1_write : m0_write;
    s_address    = gnt ? m1_address    : m0_address;
    s_writedata  = gnt ? m1_writedata  : m0_writedata;
    s_byteenable = gnt ? m1_byteenable : m0_byteenable;
    // Read wins over an illegal simultaneous write.
    s_read       = gnt_vld & sel_read;
    s_write      = gnt_vld & sel_write & ~sel_read;
    accept       = (s_read | s_write) & ~s_waitrequest;

    if (!gnt_vld) begin
      state_n = ARB;
    end else if (accept) begin
      state_n = ARB;
      ptr_n   = ~gnt;
    end else begin
      state_n = gnt ? LOCK1 : LOCK0;
    end

    m0_waitrequest = ~(accept & (gnt == 1'b0));
    m1_waitrequest = ~(accept & (gnt == 1'b1));
  end

  sdram_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .push  (accept & s_read),
    .din   (gnt),
    .pop   (s_readdatavalid),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pend_count)
  );

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & (head == 1'b0);
  assign m1_readdatavalid = pop & (head == 1'b1);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)                        err_rdv <= 1'b0;
    else if (s_readdatavalid && fifo_empty) err_rdv <= 1'b1;
  end

endmodule
